round_sequencer: RTL and testbench
==================================

# round_sequencer

Single-clock game controller for the reaction game. It sequences each round: idle, countdown, random delay, reaction window, result. It detects jump starts and first reactions, times the reaction in BCD milliseconds, and keeps per-player BCD scores. It sits between the debouncers/1 kHz tick generator and the seven-segment display mux, and replaces edge-triggered mode logic with one registered FSM.

## Interface
Parameters:
- TICKS_PER_STEP, 1000, 1 kHz ticks per countdown digit.
- COUNT_FROM, 3, first countdown digit shown (1..9).
- DELAY_MIN_MS, 1000, minimum random delay in ms.
- DELAY_BITS, 11, LFSR bits added to the delay (span 0..2^DELAY_BITS-1 ms).
- REACT_MAX_MS, 9999, reaction-window timeout (≤ 9999).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- tick_1khz  in  1  single-cycle enable, once per ms.
- start  in  1  debounced start button (level).
- switch_p1  in  1  debounced P1 switch (level).
- switch_p2  in  1  debounced P2 switch (level).
- game_mode  out  2  00 countdown/delay, 01 stopwatch, 10 score, 11 idle/blank.
- countdown_digit  out  4  current countdown digit; 0 means blank.
- react_bcd  out  16  reaction time as 4 BCD digits (s, 100 ms, 10 ms, 1 ms).
- winner  out  2  00 none, 01 P1, 10 P2, 11 tie.
- jump_start  out  1  round ended by an early switch.
- round_over  out  1  one-cycle pulse on entering RESULT.
- p1_score_bcd  out  8  P1 score, 2 BCD digits.
- p2_score_bcd  out  8  P2 score, 2 BCD digits.

## Operation
- Edge detect: start, switch_p1 and switch_p2 each have a prev register; an event is input=1 while prev=0. On rst, each prev loads the current input, so a held input never yields an event.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Seed 16'hACE1 on rst. Advances every clk.
- IDLE: game_mode=11; all outputs 0. Start event → COUNTDOWN.
- COUNTDOWN:
  - On entry: digit=COUNT_FROM, tick count=0.
  - After TICKS_PER_STEP ticks, decrement digit. When digit 1 expires → DELAY.
  - game_mode=00.
- DELAY:
  - On entry, latch delay=DELAY_MIN_MS+lfsr[DELAY_BITS-1:0] and set digit=0.
  - When the tick count reaches delay → REACT.
  - game_mode=00.
- Jump start in COUNTDOWN or DELAY → RESULT with jump_start=1 and react_bcd=0:
  - P1 event only: winner=10, P2 score +1.
  - P2 event only: winner=01, P1 score +1.
  - Both in the same cycle: winner=11, no score change.
- REACT:
  - On entry react_bcd=0. Each tick increments react_bcd in BCD. game_mode=01.
  - First switch event → RESULT; winner as for that player (both at once = 11); the winner's score +1.
  - A tick in the same cycle as an event is not counted.
  - Timeout (tick while react_bcd=REACT_MAX_MS) → RESULT with winner=00.
  - If an event and the timeout occur in the same cycle, the event wins.
- RESULT:
  - game_mode=10; react_bcd, winner and jump_start are held.
  - Start event → COUNTDOWN, clearing winner, jump_start and react_bcd.
- Start events outside IDLE/RESULT are ignored. Switch events in IDLE/RESULT are ignored.
- Scores saturate at 99 (8'h99) and clear only on rst.
- rst in any state → IDLE; scores, counters, prev registers and LFSR reinitialised per above.

## Timing
- All outputs are registered; reset value 0 for every output except game_mode=11.
- Event latency: input rising at clk edge N → prev differs at N → state/outputs change at edge N+1.
- round_over is high exactly one cycle, coincident with the first cycle of game_mode=10.
- Countdown length is exactly COUNT_FROM×TICKS_PER_STEP ticks.
- Delay length is exactly the latched delay in ticks, counted from the first tick after entry.
- react_bcd counts ticks; tick-phase jitter is at most 1 ms.

## Structure
- game_pkg holds:
  - the state enum (IDLE, COUNTDOWN, DELAY, REACT, RESULT);
  - WINNER_* and MODE_* codes;
  - LFSR_SEED and the tap mask.
- Sub-module bcd_counter (parameter DIGITS; ports clear, inc, sat, value, at_max) is used three times: react_bcd (4 digits), and each score (2 digits, saturating).
- Remaining logic (FSM, tick counters, edge detectors) lives in round_sequencer.

## Test plan
All scenarios use TICKS_PER_STEP=4, COUNT_FROM=3, DELAY_MIN_MS=5, DELAY_BITS=2, REACT_MAX_MS=20.
- Normal round: start event; countdown_digit reads 3,2,1 for 4 ticks each, then 0. After 5+lfsr[1:0] ticks game_mode=01. P1 event after 7 ticks → react_bcd=16'h0007, winner=01, round_over one cycle, p1_score_bcd=8'h01.
- Jump start: P2 event during digit 2 → winner=01, jump_start=1, react_bcd=0, p1_score_bcd increments.
- Simultaneous events in REACT → winner=11, both scores unchanged.
- Timeout: no switch for 21 ticks in REACT → react_bcd=16'h0020, winner=00, scores unchanged.
- Same-cycle event and tick/timeout: the event wins and react_bcd is not incremented.
- Saturation and reset: force 100 P1 wins → p1_score_bcd stays 8'h99. Assert rst mid-DELAY → next cycle game_mode=11, scores=0. A switch held through rst produces no event.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state, code and LFSR definitions for the reaction game
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    DELAY,
    REACT,
    RESULT
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_TIE  = 2'b11;

  localparam logic [1:0] MODE_COUNT  = 2'b00;
  localparam logic [1:0] MODE_WATCH  = 2'b01;
  localparam logic [1:0] MODE_SCORE  = 2'b10;
  localparam logic [1:0] MODE_IDLE   = 2'b11;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // Display mode the mux should show while in a given state.
  function automatic logic [1:0] state_mode(input state_t s);
    case (s)
      COUNTDOWN, DELAY: return MODE_COUNT;
      REACT:            return MODE_WATCH;
      RESULT:           return MODE_SCORE;
      default:          return MODE_IDLE;
    endcase
  endfunction

  // Binary (0..9999) to four packed BCD digits; used on parameters only.
  function automatic logic [15:0] to_bcd4(input int unsigned v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD up counter with optional saturation
module bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  inc,
  input  logic                  sat,
  output logic [4*DIGITS-1:0]   value,
  output logic                  at_max
);

  logic [4*DIGITS-1:0] value_q;
  logic [4*DIGITS-1:0] value_next;

  assign at_max = (value_q == {DIGITS{4'h9}});
  assign value  = value_q;

  // Ripple the increment through the digits, each digit wrapping 9 -> 0.
  always_comb begin
    logic carry;
    value_next = value_q;
    carry      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value_q[4*i +: 4] == 4'd9) begin
          value_next[4*i +: 4] = 4'd0;
        end else begin
          value_next[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Count register; a saturating counter holds at all nines.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value_q <= '0;
    end else if (inc && !(sat && at_max)) begin
      value_q <= value_next;
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - reaction game round FSM, timing and scoring
module round_sequencer
  import game_pkg::*;
#(
  parameter int TICKS_PER_STEP = 1000,
  parameter int COUNT_FROM     = 3,
  parameter int DELAY_MIN_MS   = 1000,
  parameter int DELAY_BITS     = 11,
  parameter int REACT_MAX_MS   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1khz,
  input  logic        start,
  input  logic        switch_p1,
  input  logic        switch_p2,
  output logic [1:0]  game_mode,
  output logic [3:0]  countdown_digit,
  output logic [15:0] react_bcd,
  output logic [1:0]  winner,
  output logic        jump_start,
  output logic        round_over,
  output logic [7:0]  p1_score_bcd,
  output logic [7:0]  p2_score_bcd
);

  // One shared tick counter serves both the countdown steps and the delay.
  localparam int CNT_W = $clog2(DELAY_MIN_MS + (1 << DELAY_BITS) + TICKS_PER_STEP + 1);
  localparam logic [15:0] REACT_MAX_BCD = to_bcd4(REACT_MAX_MS);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next, cnt_inc;
  logic [CNT_W-1:0]   delay_q, delay_next;
  logic [3:0]         digit_next;
  logic [1:0]         winner_next;
  logic               jump_next;
  logic [15:0]        lfsr_q;

  logic               prev_start, prev_p1, prev_p2;
  logic               start_ev, p1_ev, p2_ev, any_ev;
  logic [1:0]         react_winner, jump_winner;

  logic               react_clr, react_inc, p1_inc, p2_inc;
  logic               react_full, p1_full, p2_full;
  logic               unused_flags;

  assign start_ev = start & ~prev_start;
  assign p1_ev    = switch_p1 & ~prev_p1;
  assign p2_ev    = switch_p2 & ~prev_p2;
  assign any_ev   = p1_ev | p2_ev;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // In REACT the first switch wins; a jump start hands the round to the other player.
  assign react_winner = (p1_ev && p2_ev) ? WINNER_TIE : (p1_ev ? WINNER_P1 : WINNER_P2);
  assign jump_winner  = (p1_ev && p2_ev) ? WINNER_TIE : (p1_ev ? WINNER_P2 : WINNER_P1);

  // The counters' full flags are not needed: scores saturate internally and
  // the reaction timeout is compared against its own limit.
  assign unused_flags = &{1'b0, react_full, p1_full, p2_full};

  // Previous-level registers; tracking the input through reset means a level
  // held across reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    prev_start <= start;
    prev_p1    <= switch_p1;
    prev_p2    <= switch_p2;
  end

  // Free-running Fibonacci LFSR supplying the random delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // Next-state and datapath control for the round.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt_q;
    delay_next  = delay_q;
    digit_next  = countdown_digit;
    winner_next = winner;
    jump_next   = jump_start;
    react_clr   = 1'b0;
    react_inc   = 1'b0;
    p1_inc      = 1'b0;
    p2_inc      = 1'b0;

    case (state)
      IDLE, RESULT: begin
        if (start_ev) begin
          state_next  = COUNTDOWN;
          cnt_next    = '0;
          digit_next  = 4'(COUNT_FROM);
          winner_next = WINNER_NONE;
          jump_next   = 1'b0;
          react_clr   = 1'b1;
        end
      end

      COUNTDOWN, DELAY: begin
        if (any_ev) begin
          state_next  = RESULT;
          digit_next  = 4'd0;
          jump_next   = 1'b1;
          winner_next = jump_winner;
          p1_inc      = p2_ev & ~p1_ev;
          p2_inc      = p1_ev & ~p2_ev;
        end else if (tick_1khz) begin
          if (state == COUNTDOWN) begin
            if (cnt_q == CNT_W'(TICKS_PER_STEP - 1)) begin
              cnt_next = '0;
              if (countdown_digit == 4'd1) begin
                state_next = DELAY;
                digit_next = 4'd0;
                delay_next = CNT_W'(DELAY_MIN_MS) + CNT_W'(lfsr_q[DELAY_BITS-1:0]);
              end else begin
                digit_next = countdown_digit - 4'd1;
              end
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            if (cnt_inc == delay_q) begin
              state_next = REACT;
              cnt_next   = '0;
              react_clr  = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end
        end
      end

      REACT: begin
        // A switch beats a tick or timeout landing in the same cycle.
        if (any_ev) begin
          state_next  = RESULT;
          winner_next = react_winner;
          p1_inc      = p1_ev & ~p2_ev;
          p2_inc      = p2_ev & ~p1_ev;
        end else if (tick_1khz) begin
          if (react_bcd == REACT_MAX_BCD) begin
            state_next  = RESULT;
            winner_next = WINNER_NONE;
          end else begin
            react_inc = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; mode and the round_over pulse follow the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt_q           <= '0;
      delay_q         <= '0;
      countdown_digit <= 4'd0;
      winner          <= WINNER_NONE;
      jump_start      <= 1'b0;
      round_over      <= 1'b0;
      game_mode       <= MODE_IDLE;
    end else begin
      state           <= state_next;
      cnt_q           <= cnt_next;
      delay_q         <= delay_next;
      countdown_digit <= digit_next;
      winner          <= winner_next;
      jump_start      <= jump_next;
      round_over      <= (state_next == RESULT) && (state != RESULT);
      game_mode       <= state_mode(state_next);
    end
  end

  bcd_counter #(.DIGITS(4)) u_react (
    .clk    (clk),
    .rst    (rst),
    .clear  (react_clr),
    .inc    (react_inc),
    .sat    (1'b0),
    .value  (react_bcd),
    .at_max (react_full)
  );

  bcd_counter #(.DIGITS(2)) u_p1_score (
    .clk    (clk),
    .rst    (rst),
    .clear  (1'b0),
    .inc    (p1_inc),
    .sat    (1'b1),
    .value  (p1_score_bcd),
    .at_max (p1_full)
  );

  bcd_counter #(.DIGITS(2)) u_p2_score (
    .clk    (clk),
    .rst    (rst),
    .clear  (1'b0),
    .inc    (p2_inc),
    .sat    (1'b1),
    .value  (p2_score_bcd),
    .at_max (p2_full)
  );

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - directed vector bench for round_sequencer
module tb_round_sequencer;

  localparam int TPS   = 4;
  localparam int CF    = 3;
  localparam int DMIN  = 5;
  localparam int DBITS = 2;
  localparam int RMAX  = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1khz = 1'b0;
  logic        start = 1'b0;
  logic        switch_p1 = 1'b0;
  logic        switch_p2 = 1'b0;
  logic [1:0]  game_mode;
  logic [3:0]  countdown_digit;
  logic [15:0] react_bcd;
  logic [1:0]  winner;
  logic        jump_start;
  logic        round_over;
  logic [7:0]  p1_score_bcd;
  logic [7:0]  p2_score_bcd;

  int n_vec  = 0;
  int n_fail = 0;

  round_sequencer #(
    .TICKS_PER_STEP (TPS),
    .COUNT_FROM     (CF),
    .DELAY_MIN_MS   (DMIN),
    .DELAY_BITS     (DBITS),
    .REACT_MAX_MS   (RMAX)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tick_1khz       (tick_1khz),
    .start           (start),
    .switch_p1       (switch_p1),
    .switch_p2       (switch_p2),
    .game_mode       (game_mode),
    .countdown_digit (countdown_digit),
    .react_bcd       (react_bcd),
    .winner          (winner),
    .jump_start      (jump_start),
    .round_over      (round_over),
    .p1_score_bcd    (p1_score_bcd),
    .p2_score_bcd    (p2_score_bcd)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11 Fibonacci, seeded on reset.
  logic [15:0] lfsr_m;
  always_ff @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  typedef struct {
    int          phase;   // 0 react, 1 jump in countdown, 2 jump in delay
    int          pre;     // ticks before the deciding cycle (timeout: total ticks)
    logic [1:0]  sw;      // bit0 P1, bit1 P2; 0 means no switch (timeout)
    logic        tick_ev; // tick in the same cycle as the switch
    logic [1:0]  w;
    logic [15:0] react;
    logic        js;
    logic [7:0]  p1;
    logic [7:0]  p2;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_tick();
    tick_1khz = 1'b1;
    step();
    tick_1khz = 1'b0;
    step();
  endtask

  task automatic start_round();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_mode",   game_mode, 2'b00);
    check("start_digit",  countdown_digit, CF);
    check("start_winner", winner, 2'b00);
    check("start_jump",   jump_start, 1'b0);
    check("start_react",  react_bcd, 16'h0000);
  endtask

  task automatic run_countdown(input int first, input int last, output int dly);
    logic [DBITS-1:0] lat;
    lat = '0;
    for (int i = first; i < last; i++) begin
      check("cd_digit", countdown_digit, CF - i / TPS);
      lat = lfsr_m[DBITS-1:0];
      do_tick();
    end
    dly = DMIN + int'(lat);
    if (last == CF * TPS) begin
      check("cd_done_digit", countdown_digit, 4'd0);
      check("cd_done_mode",  game_mode, 2'b00);
    end
  endtask

  task automatic run_delay(input int d);
    for (int i = 0; i < d - 1; i++) do_tick();
    check("delay_mode", game_mode, 2'b00);
    do_tick();
    check("react_mode",  game_mode, 2'b01);
    check("react_entry", react_bcd, 16'h0000);
  endtask

  task automatic play(input vec_t v, input int idx);
    int d;
    int n;
    start_round();
    if (v.phase == 1) begin
      run_countdown(0, v.pre, d);
    end else begin
      run_countdown(0, CF * TPS, d);
      if (v.phase == 0) run_delay(d);
      n = (v.sw == 2'b00) ? v.pre - 1 : v.pre;
      for (int i = 0; i < n; i++) do_tick();
    end
    switch_p1 = v.sw[0];
    switch_p2 = v.sw[1];
    tick_1khz = (v.sw == 2'b00) ? 1'b1 : v.tick_ev;
    step();
    switch_p1 = 1'b0;
    switch_p2 = 1'b0;
    tick_1khz = 1'b0;
    check($sformatf("v%0d_round_over", idx), round_over, 1'b1);
    check($sformatf("v%0d_mode", idx),       game_mode, 2'b10);
    check($sformatf("v%0d_winner", idx),     winner, v.w);
    check($sformatf("v%0d_react", idx),      react_bcd, v.react);
    check($sformatf("v%0d_jump", idx),       jump_start, v.js);
    check($sformatf("v%0d_p1", idx),         p1_score_bcd, v.p1);
    check($sformatf("v%0d_p2", idx),         p2_score_bcd, v.p2);
    step();
    check($sformatf("v%0d_pulse_end", idx),  round_over, 1'b0);
    check($sformatf("v%0d_hold_mode", idx),  game_mode, 2'b10);
    check($sformatf("v%0d_hold_win", idx),   winner, v.w);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int d;
    int p1_dec;

    //          phase pre sw     tev   winner  react     js    p1     p2
    vecs[0] = '{0,    7,  2'b01, 1'b0, 2'b01, 16'h0007, 1'b0, 8'h01, 8'h00};
    vecs[1] = '{1,    4,  2'b10, 1'b0, 2'b01, 16'h0000, 1'b1, 8'h02, 8'h00};
    vecs[2] = '{1,    1,  2'b01, 1'b0, 2'b10, 16'h0000, 1'b1, 8'h02, 8'h01};
    vecs[3] = '{2,    2,  2'b01, 1'b0, 2'b10, 16'h0000, 1'b1, 8'h02, 8'h02};
    vecs[4] = '{0,    3,  2'b11, 1'b0, 2'b11, 16'h0003, 1'b0, 8'h02, 8'h02};
    vecs[5] = '{0,    21, 2'b00, 1'b0, 2'b00, 16'h0020, 1'b0, 8'h02, 8'h02};
    vecs[6] = '{0,    5,  2'b10, 1'b1, 2'b10, 16'h0005, 1'b0, 8'h02, 8'h03};
    vecs[7] = '{0,    20, 2'b01, 1'b1, 2'b01, 16'h0020, 1'b0, 8'h03, 8'h03};
    vecs[8] = '{0,    12, 2'b10, 1'b0, 2'b10, 16'h0012, 1'b0, 8'h03, 8'h04};
    vecs[9] = '{1,    6,  2'b11, 1'b0, 2'b11, 16'h0000, 1'b1, 8'h03, 8'h04};

    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_mode",   game_mode, 2'b11);
    check("rst_digit",  countdown_digit, 4'd0);
    check("rst_react",  react_bcd, 16'h0000);
    check("rst_winner", winner, 2'b00);
    check("rst_jump",   jump_start, 1'b0);
    check("rst_over",   round_over, 1'b0);
    check("rst_p1",     p1_score_bcd, 8'h00);
    check("rst_p2",     p2_score_bcd, 8'h00);

    for (int i = 0; i < 10; i++) play(vecs[i], i);

    // Switch presses in RESULT change nothing.
    switch_p1 = 1'b1;
    step();
    switch_p1 = 1'b0;
    step();
    check("result_sw_mode", game_mode, 2'b10);
    check("result_sw_win",  winner, 2'b11);
    check("result_sw_p1",   p1_score_bcd, 8'h03);
    check("result_sw_p2",   p2_score_bcd, 8'h04);

    // Saturation: 100 P1 wins via P2 jump starts.
    p1_dec = 3;
    for (int i = 0; i < 100; i++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      switch_p2 = 1'b1;
      step();
      switch_p2 = 1'b0;
      p1_dec = (p1_dec < 99) ? p1_dec + 1 : 99;
      check("sat_p1", p1_score_bcd, {4'(p1_dec / 10), 4'(p1_dec % 10)});
    end
    check("sat_final", p1_score_bcd, 8'h99);
    check("sat_p2",    p2_score_bcd, 8'h04);

    // Start presses mid-countdown are ignored, then reset mid-delay.
    start_round();
    run_countdown(0, 5, d);
    start = 1'b1;
    step();
    start = 1'b0;
    check("cd_start_ignored", countdown_digit, 4'd2);
    run_countdown(5, CF * TPS, d);
    do_tick();
    do_tick();
    check("mid_delay_mode", game_mode, 2'b00);
    rst = 1'b1;
    switch_p1 = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_mode",  game_mode, 2'b11);
    check("rst2_p1",    p1_score_bcd, 8'h00);
    check("rst2_p2",    p2_score_bcd, 8'h00);
    check("rst2_digit", countdown_digit, 4'd0);
    step();
    check("rst2_idle", game_mode, 2'b11);
    start_round();
    do_tick();
    step();
    step();
    check("held_sw_mode",  game_mode, 2'b00);
    check("held_sw_jump",  jump_start, 1'b0);
    check("held_sw_digit", countdown_digit, CF);
    switch_p1 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
